// File: rtl/ui_bus_arbiter_if.sv
// One master-side bus into the UI arbiter, plus the shared UI device codes.
`ifndef UI_DEV_CODES_SV
`define UI_DEV_CODES_SV
`define UI_KEY  2'd0
`define UI_SW   2'd1
`define UI_LEDR 2'd2
`define UI_HEX  2'd3
`endif

interface ui_bus_arbiter_if #(
    parameter int unsigned DBITS = 32,
    parameter int unsigned ABITS = 32
) ();
    // request side, driven by the bus master
    logic             req;
    logic             we;
    logic [ABITS-1:0] addr;
    logic [DBITS-1:0] wdata;

    // response side, driven by the arbiter
    logic             gnt;
    logic             rvalid;
    logic [DBITS-1:0] rdata;
    logic             err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/ui_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single UI controller port.
// Each transaction takes IDLE -> ACCESS -> RESP; no overlap between masters.
module ui_bus_arbiter #(
    parameter int unsigned     DBITS     = 32,
    parameter int unsigned     ABITS     = 32,
    parameter logic [ABITS-1:0] HEX_ADDR  = ABITS'(32'hF000_0000),
    parameter logic [ABITS-1:0] LEDR_ADDR = ABITS'(32'hF000_0004),
    parameter logic [ABITS-1:0] KEY_ADDR  = ABITS'(32'hF000_0010),
    parameter logic [ABITS-1:0] SW_ADDR   = ABITS'(32'hF000_0014)
) (
    input  logic             clk,
    input  logic             reset,
    ui_bus_arbiter_if.slave  m0_if,
    ui_bus_arbiter_if.slave  m1_if,
    output logic             ui_wrtEn_o,
    output logic [1:0]       ui_dev_o,
    output logic [DBITS-1:0] ui_wdata_o,
    input  logic [DBITS-1:0] ui_rdata_i
);

    localparam int unsigned DEV_BITS = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    // Decoded request: device code plus error flag
    typedef struct packed {
        logic                err;
        logic [DEV_BITS-1:0] dev;
    } decode_t;

    state_e                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    owner_q, owner_d;
    logic                    we_q, we_d;
    logic                    err_q, err_d;
    logic [DEV_BITS-1:0]     ui_dev_q, ui_dev_d;
    logic [DBITS-1:0]        ui_wdata_q, ui_wdata_d;
    logic                    ui_wrten_q, ui_wrten_d;
    logic [1:0]              gnt_q, gnt_d;
    logic [1:0]              rvalid_q, rvalid_d;
    logic [1:0]              rerr_q, rerr_d;
    logic [1:0][DBITS-1:0]   rdata_q, rdata_d;

    logic                    winner_c;
    logic                    win_we_c;
    logic [ABITS-1:0]        win_addr_c;
    logic [DBITS-1:0]        win_wdata_c;
    decode_t                 win_dec_c;
    logic                    unused_addr_lsb_c;

    // Word-address decode; byte-offset bits never take part
    function automatic decode_t decode(input logic [ABITS-1:0] addr, input logic we);
        decode_t d;
        d.err = 1'b0;
        d.dev = `UI_KEY;
        if (addr[ABITS-1:2] == HEX_ADDR[ABITS-1:2]) begin
            d.dev = `UI_HEX;
        end else if (addr[ABITS-1:2] == LEDR_ADDR[ABITS-1:2]) begin
            d.dev = `UI_LEDR;
        end else if (addr[ABITS-1:2] == KEY_ADDR[ABITS-1:2]) begin
            d.dev = `UI_KEY;
            d.err = we;
        end else if (addr[ABITS-1:2] == SW_ADDR[ABITS-1:2]) begin
            d.dev = `UI_SW;
            d.err = we;
        end else begin
            d.err = 1'b1;
        end
        return d;
    endfunction

    // Round-robin pick: a lone requester wins, contention goes to the master that was not last
    always_comb begin
        if (m0_if.req && m1_if.req) begin
            winner_c = ~last_q;
        end else begin
            winner_c = m1_if.req;
        end
        win_we_c    = winner_c ? m1_if.we    : m0_if.we;
        win_addr_c  = winner_c ? m1_if.addr  : m0_if.addr;
        win_wdata_c = winner_c ? m1_if.wdata : m0_if.wdata;
        win_dec_c   = decode(win_addr_c, win_we_c);
    end

    assign unused_addr_lsb_c = ^{m0_if.addr[1:0], m1_if.addr[1:0]};

    // Next-state and registered-output logic for the transaction sequencer
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        we_d       = we_q;
        err_d      = err_q;
        ui_dev_d   = ui_dev_q;
        ui_wdata_d = ui_wdata_q;
        ui_wrten_d = 1'b0;
        gnt_d      = '0;
        rvalid_d   = '0;
        rerr_d     = '0;
        rdata_d    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (m0_if.req || m1_if.req) begin
                    owner_d           = winner_c;
                    last_d            = winner_c;
                    we_d              = win_we_c;
                    err_d             = win_dec_c.err;
                    ui_dev_d          = win_dec_c.dev;
                    ui_wdata_d        = win_wdata_c;
                    gnt_d[winner_c]   = 1'b1;
                    ui_wrten_d        = win_we_c && !win_dec_c.err &&
                                        ((win_dec_c.dev == `UI_HEX) ||
                                         (win_dec_c.dev == `UI_LEDR));
                    state_d           = S_ACCESS;
                end
            end
            S_ACCESS: begin
                rvalid_d[owner_q] = 1'b1;
                rerr_d[owner_q]   = err_q;
                rdata_d[owner_q]  = (we_q || err_q) ? '0 : ui_rdata_i;
                state_d           = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            ui_dev_q   <= '0;
            ui_wdata_q <= '0;
            ui_wrten_q <= 1'b0;
            gnt_q      <= '0;
            rvalid_q   <= '0;
            rerr_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            err_q      <= err_d;
            ui_dev_q   <= ui_dev_d;
            ui_wdata_q <= ui_wdata_d;
            ui_wrten_q <= ui_wrten_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            rerr_q     <= rerr_d;
            rdata_q    <= rdata_d;
        end
    end

    // The UI controller commits on the negedge inside ACCESS, so a reset raised
    // during ACCESS must suppress the write before that edge.
    assign ui_wrtEn_o = ui_wrten_q & ~reset;
    assign ui_dev_o   = ui_dev_q;
    assign ui_wdata_o = ui_wdata_q;

    assign m0_if.gnt    = gnt_q[0];
    assign m0_if.rvalid = rvalid_q[0];
    assign m0_if.err    = rerr_q[0];
    assign m0_if.rdata  = rdata_q[0];

    assign m1_if.gnt    = gnt_q[1];
    assign m1_if.rvalid = rvalid_q[1];
    assign m1_if.err    = rerr_q[1];
    assign m1_if.rdata  = rdata_q[1];

endmodule

// File: tb/tb_ui_bus_arbiter.sv
// Directed bench for ui_bus_arbiter with a small UI controller model.
module tb_ui_bus_arbiter;

    localparam int unsigned DBITS = 32;
    localparam int unsigned ABITS = 32;

    localparam logic [31:0] HEX_ADDR  = 32'hF000_0000;
    localparam logic [31:0] LEDR_ADDR = 32'hF000_0004;
    localparam logic [31:0] KEY_ADDR  = 32'hF000_0010;
    localparam logic [31:0] SW_ADDR   = 32'hF000_0014;

    logic             clk = 1'b0;
    logic             reset;
    logic             ui_wrtEn;
    logic [1:0]       ui_dev;
    logic [DBITS-1:0] ui_wdata;
    logic [DBITS-1:0] ui_rdata;

    // UI controller model state
    logic [31:0] hex_reg  = 32'h0;
    logic [31:0] ledr_reg = 32'h0;
    logic [31:0] key_val  = 32'h5;
    logic [31:0] sw_val   = 32'h155;

    int n_tests = 0;
    int n_fail  = 0;

    ui_bus_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) m0_bus ();
    ui_bus_arbiter_if #(.DBITS(DBITS), .ABITS(ABITS)) m1_bus ();

    ui_bus_arbiter #(.DBITS(DBITS), .ABITS(ABITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_if      (m0_bus),
        .m1_if      (m1_bus),
        .ui_wrtEn_o (ui_wrtEn),
        .ui_dev_o   (ui_dev),
        .ui_wdata_o (ui_wdata),
        .ui_rdata_i (ui_rdata)
    );

    always #5 clk = ~clk;

    // UI controller: combinational read, write committed on negedge
    always_comb begin
        case (ui_dev)
            `UI_KEY:  ui_rdata = key_val;
            `UI_SW:   ui_rdata = sw_val;
            `UI_LEDR: ui_rdata = ledr_reg;
            default:  ui_rdata = hex_reg;
        endcase
    end

    always @(negedge clk) begin
        if (ui_wrtEn) begin
            if (ui_dev == `UI_HEX)  hex_reg  <= ui_wdata;
            if (ui_dev == `UI_LEDR) ledr_reg <= ui_wdata;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int m, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
        end else begin
            m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
        end
    endtask

    // One full transaction: request, ACCESS-cycle checks, RESP-cycle checks, back to IDLE
    task automatic run_txn(input string tag, input int m, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_wr, input logic [1:0] exp_dev,
                           input logic exp_err, input logic [31:0] exp_rdata);
        logic own_gnt, oth_gnt, own_rv, oth_rv, own_err;
        logic [31:0] own_rd, oth_rd;
        drive_req(m, 1'b1, we, addr, wdata);
        tick();
        own_gnt = (m == 0) ? m0_bus.gnt : m1_bus.gnt;
        oth_gnt = (m == 0) ? m1_bus.gnt : m0_bus.gnt;
        check_eq({tag, "_gnt"}, 32'(own_gnt), 32'd1);
        check_eq({tag, "_other_gnt"}, 32'(oth_gnt), 32'd0);
        check_eq({tag, "_wrten"}, 32'(ui_wrtEn), 32'(exp_wr));
        if (!exp_err) check_eq({tag, "_dev"}, 32'(ui_dev), 32'(exp_dev));
        if (exp_wr)   check_eq({tag, "_wdata"}, ui_wdata, wdata);
        drive_req(m, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        own_rv  = (m == 0) ? m0_bus.rvalid : m1_bus.rvalid;
        oth_rv  = (m == 0) ? m1_bus.rvalid : m0_bus.rvalid;
        own_err = (m == 0) ? m0_bus.err    : m1_bus.err;
        own_rd  = (m == 0) ? m0_bus.rdata  : m1_bus.rdata;
        oth_rd  = (m == 0) ? m1_bus.rdata  : m0_bus.rdata;
        check_eq({tag, "_rvalid"}, 32'(own_rv), 32'd1);
        check_eq({tag, "_other_rvalid"}, 32'(oth_rv), 32'd0);
        check_eq({tag, "_err"}, 32'(own_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, own_rd, exp_rdata);
        check_eq({tag, "_other_rdata"}, oth_rd, 32'h0);
        check_eq({tag, "_resp_wrten"}, 32'(ui_wrtEn), 32'd0);
        tick();
        check_eq({tag, "_rvalid_drop"}, 32'({m1_bus.rvalid, m0_bus.rvalid}), 32'd0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        apply_reset();

        // reset state
        check_eq("rst_gnt",    32'({m1_bus.gnt, m0_bus.gnt}), 32'd0);
        check_eq("rst_rvalid", 32'({m1_bus.rvalid, m0_bus.rvalid}), 32'd0);
        check_eq("rst_err",    32'({m1_bus.err, m0_bus.err}), 32'd0);
        check_eq("rst_rdata0", m0_bus.rdata, 32'h0);
        check_eq("rst_wrten",  32'(ui_wrtEn), 32'd0);
        check_eq("rst_dev",    32'(ui_dev), 32'd0);
        check_eq("rst_wdata",  ui_wdata, 32'h0);

        // 1: m0 writes LEDR
        run_txn("t1_ledr_wr", 0, 1'b1, LEDR_ADDR, 32'h3FF, 1'b1, `UI_LEDR, 1'b0, 32'h0);
        check_eq("t1_ledr_model", ledr_reg, 32'h3FF);

        // 2: m1 reads SW
        run_txn("t2_sw_rd", 1, 1'b0, SW_ADDR, 32'h0, 1'b0, `UI_SW, 1'b0, 32'h155);

        // 3: contention from reset, grants alternate 0,1,0,1
        apply_reset();
        drive_req(0, 1'b1, 1'b0, LEDR_ADDR, 32'h0);
        drive_req(1, 1'b1, 1'b0, SW_ADDR, 32'h0);
        k = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq("t3_no_dual_gnt", 32'(m0_bus.gnt & m1_bus.gnt), 32'd0);
            if (m0_bus.gnt || m1_bus.gnt) begin
                check_eq("t3_rr_order", 32'(m1_bus.gnt), 32'(k % 2));
                k++;
            end
        end
        drive_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("t3_gnt_count", 32'(k), 32'd4);
        tick();
        tick();
        tick();

        // 4: write to read-only KEY and read of an unmapped address
        run_txn("t4_key_wr", 0, 1'b1, KEY_ADDR, 32'hDEAD, 1'b0, `UI_KEY, 1'b1, 32'h0);
        run_txn("t4_unmapped", 0, 1'b0, 32'hF000_0020, 32'h0, 1'b0, `UI_KEY, 1'b1, 32'h0);

        // 5: reset during ACCESS of an m1 HEX write drops the transaction
        drive_req(1, 1'b1, 1'b1, HEX_ADDR, 32'hABCD);
        tick();
        check_eq("t5_gnt_before_rst", 32'(m1_bus.gnt), 32'd1);
        reset = 1'b1;
        drive_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check_eq("t5_wrten_gated", 32'(ui_wrtEn), 32'd0);
        tick();
        check_eq("t5_rst_rvalid", 32'({m1_bus.rvalid, m0_bus.rvalid}), 32'd0);
        check_eq("t5_rst_dev", 32'(ui_dev), 32'd0);
        check_eq("t5_rst_wdata", ui_wdata, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("t5_no_rvalid", 32'({m1_bus.rvalid, m0_bus.rvalid}), 32'd0);
        check_eq("t5_hex_unchanged", hex_reg, 32'h0);
        run_txn("t5_hex_wr", 1, 1'b1, HEX_ADDR, 32'h1234, 1'b1, `UI_HEX, 1'b0, 32'h0);
        check_eq("t5_hex_model", hex_reg, 32'h1234);

        // 6: byte offset within HEX is ignored
        run_txn("t6_hex_rd", 0, 1'b0, HEX_ADDR + 32'd3, 32'h0, 1'b0, `UI_HEX, 1'b0, 32'h1234);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
